axis_tx_hssi_pkt_arbiter: RTL
=============================

// Module: axis_tx_hssi_pkt_arbiter
//
// PURPOSE
//  Packet-granular round-robin arbiter sharing one HSSI TX AXI-Stream channel
//  between NUM_REQ client streams. Sits between the AFU-side TX sources and the
//  TX pipeline stage that feeds the HSSI MAC.
//  A grant is held from the first beat of a packet until its tlast beat is
//  accepted, so packets are never interleaved.
//  The output is registered: one beat of latency, full throughput while locked.
//
// PARAMETERS
//  NUM_REQ      4    number of requesting streams (2..8)
//  TDATA_WIDTH  512  tdata width; tkeep width is TDATA_WIDTH/8
//  TUSER_WIDTH  10   tuser width
//
// PORTS
//  clk        in   1                   clock for all ports
//  rst_n      in   1                   async assert, active-low reset
//  s_tvalid   in   NUM_REQ             per-requester valid
//  s_tready   out  NUM_REQ             per-requester ready
//  s_tdata    in   NUM_REQ*TDATA_WIDTH requester i at [i*TDATA_WIDTH +: TDATA_WIDTH]
//  s_tkeep    in   NUM_REQ*TDATA_WIDTH/8  packed like s_tdata
//  s_tlast    in   NUM_REQ             per-requester end of packet
//  s_tuser    in   NUM_REQ*TUSER_WIDTH packed like s_tdata
//  m_tvalid   out  1                   to HSSI TX pipeline
//  m_tready   in   1
//  m_tdata    out  TDATA_WIDTH
//  m_tkeep    out  TDATA_WIDTH/8
//  m_tlast    out  1
//  m_tuser    out  TUSER_WIDTH
//  grant_id   out  $clog2(NUM_REQ)     index of the current or last owner
//  busy       out  1                   1 while in LOCK (packet in flight)
//
// BEHAVIOUR
//  Reset (rst_n=0, async): m_tvalid=0, m_tlast=0, m_tdata/tkeep/tuser=0, s_tready=0,
//   grant_id=0, busy=0, rr_ptr=0, state=IDLE. Outputs hold these values until the
//   first clk edge after deassertion.
//  States:
//   IDLE: select the first i with s_tvalid[i]=1, scanning rr_ptr, rr_ptr+1, ..
//    (mod NUM_REQ). Register grant_id=i and go to LOCK. No beat moves in IDLE.
//    If no request is valid, stay in IDLE.
//   LOCK: s_tready[grant_id] = ~m_tvalid | m_tready; all other s_tready bits = 0.
//    An accepted beat (s_tvalid & s_tready) loads the output register next cycle.
//    When the accepted beat has s_tlast=1: set rr_ptr = (grant_id+1) mod NUM_REQ
//    and go to DRAIN.
//   DRAIN: all s_tready=0. Return to IDLE once the output register is empty, or
//    is emptying this cycle (m_tvalid=0 or m_tready=1).
//  Output register: load on an accepted input beat. Otherwise clear m_tvalid when
//   m_tready=1. Hold all m_* stable while m_tvalid=1 and m_tready=0 (AXIS rule).
//  Latency: input accept to m_tvalid = 1 cycle.
//   Arbitration overhead per packet = 1 IDLE cycle, plus DRAIN cycles.
//  busy=1 only in LOCK. grant_id holds its value through DRAIN and IDLE until the
//   next grant.
//  Boundaries:
//   - A 1-beat packet (tlast on the first beat) is legal: LOCK lasts 1 cycle.
//   - A requester dropping s_tvalid mid-packet keeps the lock; no other port is served.
//   - If every requester is valid, each gets exactly one packet per round in
//     rr_ptr order.
//   - NUM_REQ not a power of 2: the wrap uses compare-to-NUM_REQ-1, never bit truncation.
//   - Reset mid-packet: the in-flight beat is discarded and no partial-packet
//     recovery is attempted; upstream and downstream are reset together.
//
// TESTING
//  1. Reset: rst_n=0 with random inputs -> m_tvalid=0, s_tready=0, grant_id=0, busy=0.
//  2. Req0 sends a 3-beat packet, m_tready=1 -> 3 m beats, tlast on the 3rd,
//     first m_tvalid 1 cycle after the first accept; then rr_ptr=1.
//  3. All 4 requesters send 2-beat packets continuously -> grant order 0,1,2,3,0;
//     no interleaving within a packet.
//  4. m_tready toggles 1010.. during a packet -> m_* stable while stalled;
//     the beat sequence is unchanged.
//  5. Req2 drops tvalid for 5 cycles mid-packet while req1 is valid -> req1
//     s_tready stays 0 until req2's tlast is accepted.
//  6. rst_n asserted during beat 2 of 4 -> outputs clear immediately;
//     after release, a new packet from req3 arbitrates normally.

Source files
------------

// File: rtl/axis_tx_hssi_pkt_arbiter.sv
// rtl/axis_tx_hssi_pkt_arbiter.sv - packet-granular round-robin arbiter onto one HSSI TX AXI-Stream
// Grants are held from the first beat to the accepted tlast beat; the output stage is a single register.
module axis_tx_hssi_pkt_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 s_tvalid,
    output logic [NUM_REQ-1:0]                 s_tready,
    input  logic [NUM_REQ*TDATA_WIDTH-1:0]     s_tdata,
    input  logic [NUM_REQ*TDATA_WIDTH/8-1:0]   s_tkeep,
    input  logic [NUM_REQ-1:0]                 s_tlast,
    input  logic [NUM_REQ*TUSER_WIDTH-1:0]     s_tuser,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [TDATA_WIDTH-1:0]             m_tdata,
    output logic [TDATA_WIDTH/8-1:0]           m_tkeep,
    output logic                               m_tlast,
    output logic [TUSER_WIDTH-1:0]             m_tuser,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               busy
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int KEEP_W = TDATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, LOCK, DRAIN} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   pick;
    logic              found;
    int                idx;
    logic              out_rdy;
    logic              accept;
    logic              sel_valid;
    logic              sel_last;
    logic [ID_W-1:0]   next_ptr;

    // Scan from rr_ptr with an explicit wrap so non-power-of-two NUM_REQ works.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && s_tvalid[idx]) begin
                found = 1'b1;
                pick  = idx[ID_W-1:0];
            end
        end
    end

    assign out_rdy   = ~m_tvalid | m_tready;
    assign sel_valid = s_tvalid[grant_id];
    assign sel_last  = s_tlast[grant_id];
    assign accept    = (state == LOCK) & sel_valid & out_rdy;
    assign busy      = (state == LOCK);
    assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        s_tready = '0;
        if (state == LOCK) s_tready[grant_id] = out_rdy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tuser  <= '0;
        end else begin
            if (accept) begin
                m_tvalid <= 1'b1;
                m_tlast  <= sel_last;
                m_tdata  <= s_tdata[int'(grant_id)*TDATA_WIDTH +: TDATA_WIDTH];
                m_tkeep  <= s_tkeep[int'(grant_id)*KEEP_W +: KEEP_W];
                m_tuser  <= s_tuser[int'(grant_id)*TUSER_WIDTH +: TUSER_WIDTH];
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= pick;
                        state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept && sel_last) begin
                        rr_ptr <= next_ptr;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave once the tlast beat is gone or leaving this cycle.
                    if (out_rdy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
